// File: rtl/alu64bit_serial.sv
// Digit-serial ALU: one BITS_PER_CYCLE-wide slice iterated LSB-first with a registered carry.
// Optional zero/ovf flag outputs are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu64bit_serial #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned B       = BITS_PER_CYCLE;
  localparam int unsigned Steps   = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW    = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, s_q;
  logic [1:0]        op_q;
  logic              carry_q, cout_q, in_ready_q, out_valid_q;
  logic [CntW-1:0]   cnt_q;

  logic [B-1:0]      a_sl, b_sl, b_eff, slice;
  logic [B:0]        sum;
  logic              carry_d;
  logic [WIDTH+B-1:0] s_cat;

`ifdef ALU_SERIAL_FLAGS_EN
  logic nz_q, zero_q, ovf_q, msb_cin;
`endif

  always_comb begin
    a_sl    = a_q[B-1:0];
    b_sl    = b_q[B-1:0];
    b_eff   = op_q[0] ? ~b_sl : b_sl;
    sum     = {1'b0, a_sl} + {1'b0, b_eff} + {{B{1'b0}}, carry_q};
    slice   = sum[B-1:0];
    case (op_q)
      2'b00:   slice = ~(a_sl | b_sl);
      2'b01:   slice = a_sl ^ b_sl;
      default: slice = sum[B-1:0];
    endcase
    carry_d = op_q[1] & sum[B];
    // New slice enters at the MSB end; after the last step every slice sits in place.
    s_cat   = {slice, s_q};
  end

`ifdef ALU_SERIAL_FLAGS_EN
  assign msb_cin = a_sl[B-1] ^ b_eff[B-1] ^ sum[B-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      op_q        <= 2'b00;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      nz_q        <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
`ifdef ALU_SERIAL_FLAGS_EN
            nz_q       <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
`endif
          end
        end
        StRun: begin
          a_q     <= a_q >> B;
          b_q     <= b_q >> B;
          s_q     <= s_cat[WIDTH+B-1:B];
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CntW'(1);
`ifdef ALU_SERIAL_FLAGS_EN
          nz_q    <= nz_q | (|slice);
`endif
          if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            cout_q      <= carry_d;
`ifdef ALU_SERIAL_FLAGS_EN
            zero_q      <= ~(nz_q | (|slice));
            ovf_q       <= op_q[1] & (msb_cin ^ sum[B]);
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu64bit_serial.sv
// Directed bench for alu64bit_serial: scoreboard of model results, latency, back-pressure, reset.
module tb_alu64bit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, s;
  logic        cin, cout;
  logic [1:0]  op;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [63:0] s8;
  logic        cout8;
`ifdef ALU_SERIAL_FLAGS_EN
  logic zero, ovf, zero8, ovf8;
`endif

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu64bit_serial #(.WIDTH(64), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ALU_SERIAL_FLAGS_EN
    .zero(zero), .ovf(ovf),
`endif
    .s(s), .cout(cout)
  );

  alu64bit_serial #(.WIDTH(64), .BITS_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef ALU_SERIAL_FLAGS_EN
    .zero(zero8), .ovf(ovf8),
`endif
    .s(s8), .cout(cout8)
  );

  function automatic exp_t model(logic [63:0] ma, logic [63:0] mb, logic mc, logic [1:0] mop);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] bb;
    e  = '0;
    bb = mop[0] ? ~mb : mb;
    case (mop)
      2'b00: e.s = ~(ma | mb);
      2'b01: e.s = ma ^ mb;
      default: begin
        full   = {1'b0, ma} + {1'b0, bb} + {64'd0, mc};
        e.s    = full[63:0];
        e.cout = full[64];
        e.ovf  = (ma[63] == bb[63]) && (e.s[63] != ma[63]);
      end
    endcase
    e.zero = (e.s == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present operands and return once the accepting edge has passed.
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                          input logic [1:0] top);
    int guard = 0;
    a = ta; b = tb_; cin = tc; op = top;
    exp_q.push_back(model(ta, tb_, tc, top));
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_timeout", 64'(guard < 20), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int   lat = 1;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_s"}, s, e.s);
      check({tag, "_cout"}, 64'(cout), 64'(e.cout));
`ifdef ALU_SERIAL_FLAGS_EN
      check({tag, "_zero"}, 64'(zero), 64'(e.zero));
      check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
`endif
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic full_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic tc, input logic [1:0] top);
    start_op(ta, tb_, tc, top);
    wait_result(tag, 65);
    release_out(tag);
  endtask

  initial begin
    logic [63:0] held_s;
    logic        held_c;
    exp_t        e8;
    int          lat8;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s", s, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    full_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10);
    full_op("sub_neg", 64'd5, 64'd7, 1'b1, 2'b11);
    full_op("sub_pos", 64'd7, 64'd5, 1'b1, 2'b11);
    full_op("nor", 64'h0F0F_0000_0000_FFFF, 64'h00F0_0000_0000_0F00, 1'b0, 2'b00);
    full_op("xor", 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01);
    full_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10);

    // Back-pressure: result must hold while a second bundle is offered and refused.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 2'b10);
    wait_result("bp", 65);
    held_s = s; held_c = cout;
    for (int i = 0; i < 10; i++) begin
      a = 64'(i) * 64'h1111; b = ~a; op = 2'(i); cin = i[0];
      in_valid = i[0];
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_s_hold", s, held_s);
      check("bp_cout_hold", 64'(cout), 64'(held_c));
      check("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    release_out("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_capture", 64'(out_valid), 64'd0);
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    full_op("after_bp", 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 2'b01);

    // Reset partway through RUN discards the operation.
    start_op(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 2'b10);
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rstrun_out_valid", 64'(out_valid), 64'd0);
    check("rstrun_in_ready", 64'(in_ready), 64'd0);
    check("rstrun_s", s, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    full_op("add_3_4", 64'd3, 64'd4, 1'b0, 2'b10);

    // Reset while DONE drops out_valid without a clock edge.
    start_op(64'd9, 64'd3, 1'b1, 2'b11);
    wait_result("rstdone", 65);
    #2 rst_n = 1'b0;
    #1;
    check("rstdone_out_valid", 64'(out_valid), 64'd0);
    check("rstdone_cout", 64'(cout), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Eight bits per cycle: latency shrinks to WIDTH/8 + 1 edges.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; op = 2'b10;
    e8 = model(a, b, cin, op);
    check("b8_in_ready", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat8 = 1;
    while (!out_valid8 && lat8 < 50) begin
      @(posedge clk); #1; lat8++;
    end
    check("b8_latency", 64'(lat8), 64'd9);
    check("b8_s", s8, e8.s);
    check("b8_cout", 64'(cout8), 64'(e8.cout));
`ifdef ALU_SERIAL_FLAGS_EN
    check("b8_zero", 64'(zero8), 64'(e8.zero));
    check("b8_ovf", 64'(ovf8), 64'(e8.ovf));
`endif
    a = 64'h0123_4567_89AB_CDEF; b = 64'h0000_0000_0000_00FF; cin = 1'b1; op = 2'b11;
    e8 = model(a, b, cin, op);
    @(posedge clk); #1;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat8 = 1;
    while (!out_valid8 && lat8 < 50) begin
      @(posedge clk); #1; lat8++;
    end
    check("b8_sub_latency", 64'(lat8), 64'd9);
    check("b8_sub_s", s8, e8.s);
    check("b8_sub_cout", 64'(cout8), 64'(e8.cout));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
